// File: rtl/tm_sched_if.sv
// Request/grant and measurement-window signals between channel front-ends and tm_sched.
// master drives requests and the ce time base; slave is the scheduler.
interface tm_sched_if #(
   parameter int unsigned N = 4
) ();
   localparam int unsigned ChW = (N > 1) ? $clog2(N) : 1;

   logic           ce;
   logic [N-1:0]   req;
   logic           abort;
   logic [N-1:0]   gnt;
   logic [ChW-1:0] ch;
   logic           Tm;
   logic           done;
   logic           busy;

   modport master (
      output ce, req, abort,
      input  gnt, ch, Tm, done, busy
   );

   modport slave (
      input  ce, req, abort,
      output gnt, ch, Tm, done, busy
   );
endinterface

// File: rtl/tm_sched.sv
// Round-robin owner of the shared Tm window generator: grants one requester, opens a window of
// 1<<M ce-ticks aligned to ce, pulses done at its end, then holds a GAP-tick guard interval.
module tm_sched #(
   parameter int unsigned N   = 4,
   parameter int unsigned M   = 4,
   parameter int unsigned GAP = 2
) (
   input logic       clk,
   input logic       rst_n,
   tm_sched_if.slave sif
);
   localparam int unsigned ChW  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned GapW = $clog2(GAP + 1);
   localparam int unsigned CntW = ((M + 1) > GapW) ? (M + 1) : GapW;
   localparam logic [CntW-1:0] NpVal  = CntW'(1) << M;
   localparam logic [CntW-1:0] GapVal = CntW'(GAP);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   typedef enum logic [1:0] {StIdle, StArm, StWin, StGap} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [ChW-1:0]  ptr_q, ptr_d;
   logic [ChW-1:0]  ch_q, ch_d;
   logic [N-1:0]    gnt_q, gnt_d;
   logic            tm_q, tm_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   logic            sel_found;
   logic [ChW-1:0]  sel_idx;
   logic [ChW-1:0]  cand;
   logic            req_lost;
   logic            last_tick;

   // First requester after the last granted one, wrapping modulo N.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = ChW'((32'(ptr_q) + k) % N);
         if (!sel_found && sif.req[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   assign req_lost  = !sif.req[ch_q];
   assign last_tick = (cnt_q == CntOne);

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ptr_q   <= ChW'(N - 1);
         ch_q    <= '0;
         gnt_q   <= '0;
         tm_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         ch_q    <= ch_d;
         gnt_q   <= gnt_d;
         tm_q    <= tm_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; abort outranks ce and the terminal count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (sel_found) state_d = StArm;
         end
         StArm: begin
            if (sif.abort || req_lost) state_d = StIdle;
            else if (sif.ce)           state_d = StWin;
         end
         StWin: begin
            if (sif.abort) begin
               state_d = StIdle;
            end else if (sif.ce && last_tick) begin
               state_d = (GAP > 0) ? StGap : StIdle;
            end
         end
         StGap: begin
            if (sif.ce && last_tick) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs and datapath.
   always_comb begin
      cnt_d  = cnt_q;
      ptr_d  = ptr_q;
      ch_d   = ch_q;
      gnt_d  = gnt_q;
      tm_d   = tm_q;
      done_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (sel_found) begin
               gnt_d          = '0;
               gnt_d[sel_idx] = 1'b1;
               ch_d           = sel_idx;
               ptr_d          = sel_idx;
            end
         end
         StArm: begin
            // A cancelled grant keeps ptr, so the dropped channel loses its turn.
            if (sif.abort || req_lost) begin
               gnt_d = '0;
            end else if (sif.ce) begin
               tm_d  = 1'b1;
               cnt_d = NpVal;
            end
         end
         StWin: begin
            if (sif.abort) begin
               tm_d  = 1'b0;
               gnt_d = '0;
            end else if (sif.ce) begin
               if (last_tick) begin
                  tm_d   = 1'b0;
                  gnt_d  = '0;
                  done_d = 1'b1;
                  if (GAP > 0) cnt_d = GapVal;
               end else begin
                  cnt_d = cnt_q - CntOne;
               end
            end
         end
         StGap: begin
            if (sif.ce && !last_tick) cnt_d = cnt_q - CntOne;
         end
         default: begin
            tm_d  = 1'b0;
            gnt_d = '0;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   assign sif.gnt  = gnt_q;
   assign sif.ch   = ch_q;
   assign sif.Tm   = tm_q;
   assign sif.done = done_q;
   assign sif.busy = busy_q;
endmodule

// File: tb/tb_tm_sched.sv
// Directed bench for tm_sched: one instance with GAP=2 and ce every 3rd clk, one with GAP=0
// and ce tied high; both N=4, M=2 (4-tick windows).
module tb_tm_sched;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   phase  = 0;
   logic ce_edge = 1'b0;

   tm_sched_if #(.N(4)) sa ();
   tm_sched_if #(.N(4)) sb ();

   tm_sched #(.N(4), .M(2), .GAP(2)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sa)
   );

   tm_sched #(.N(4), .M(2), .GAP(0)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // One clk; ce_edge holds the ce value the edge sampled, sa.ce is set for the next edge.
   task automatic step();
      ce_edge = sa.ce;
      @(posedge clk);
      #1;
      phase = (phase == 2) ? 0 : phase + 1;
      sa.ce = (phase == 2);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // From a granted ARM state: Tm must stay high 12 clk and end with a single done.
   task automatic measure_window(input int exp_ch);
      bit found;
      int hi;
      int dn;
      found = 1'b0;
      hi    = 1;
      dn    = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (sa.Tm) begin
            found = 1'b1;
            break;
         end
      end
      chk("tm_rise", 32'(found), 32'd1);
      chk("gnt_at_rise", 32'(sa.gnt), 32'(1) << exp_ch);
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (sa.done) dn++;
         if (!sa.Tm) begin
            found = 1'b1;
            break;
         end
         hi++;
      end
      chk("tm_fall", 32'(found), 32'd1);
      chk("tm_clocks", 32'(hi), 32'd12);
      chk("done_count", 32'(dn), 32'd1);
      chk("done_at_fall", 32'(sa.done), 32'd1);
      chk("done_ch", 32'(sa.ch), 32'(exp_ch));
      chk("gnt_clear", 32'(sa.gnt), 32'd0);
   endtask

   // After a window end: count guard ce-ticks until the next grant.
   task automatic wait_grant(input int exp_ch, input int exp_ces);
      bit found;
      bit last;
      int ces;
      found = 1'b0;
      last  = 1'b0;
      ces   = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (sa.gnt != '0) begin
            found = 1'b1;
            break;
         end
         last = ce_edge;
         if (ce_edge) ces++;
      end
      chk("regrant_seen", 32'(found), 32'd1);
      chk("gap_ticks", 32'(ces), 32'(exp_ces));
      chk("grant_after_last_ce", 32'(last), 32'd1);
      chk("regrant_gnt", 32'(sa.gnt), 32'(1) << exp_ch);
      chk("regrant_ch", 32'(sa.ch), 32'(exp_ch));
   endtask

   initial begin
      rst_n    = 1'b0;
      sa.ce    = 1'b0;
      sa.req   = '0;
      sa.abort = 1'b0;
      sb.ce    = 1'b1;
      sb.req   = '0;
      sb.abort = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      chk("rst_tm", 32'(sa.Tm), 32'd0);
      chk("rst_gnt", 32'(sa.gnt), 32'd0);
      chk("rst_ch", 32'(sa.ch), 32'd0);
      chk("rst_done", 32'(sa.done), 32'd0);
      chk("rst_busy", 32'(sa.busy), 32'd0);

      // Single channel held: 1-clk grant latency, 12-clk window, 2-tick guard.
      sa.req = 4'b0001;
      step();
      chk("single_gnt", 32'(sa.gnt), 32'd1);
      chk("single_busy", 32'(sa.busy), 32'd1);
      chk("single_tm_low", 32'(sa.Tm), 32'd0);
      measure_window(0);
      wait_grant(0, 2);
      sa.req = '0;
      step();
      chk("drop_busy", 32'(sa.busy), 32'd0);
      chk("drop_gnt", 32'(sa.gnt), 32'd0);

      // Fairness from reset: 0,1,2,3,0.
      do_reset();
      sa.req = 4'b1111;
      step();
      chk("fair_first_gnt", 32'(sa.gnt), 32'd1);
      measure_window(0);
      for (int k = 1; k <= 4; k++) begin
         wait_grant(k % 4, 2);
         measure_window(k % 4);
      end
      sa.req = '0;
      repeat (10) step();
      chk("fair_idle", 32'(sa.busy), 32'd0);

      // Cancel in ARM: ptr moved to 2 on the grant and stays there.
      sa.req = 4'b0100;
      step();
      chk("cancel_gnt", 32'(sa.gnt), 32'h4);
      chk("cancel_ch", 32'(sa.ch), 32'd2);
      sa.req = '0;
      step();
      chk("cancel_gnt_clr", 32'(sa.gnt), 32'd0);
      chk("cancel_busy", 32'(sa.busy), 32'd0);
      chk("cancel_tm", 32'(sa.Tm), 32'd0);
      sa.req = 4'b0101;
      step();
      chk("cancel_next_ch", 32'(sa.ch), 32'd0);
      chk("cancel_next_gnt", 32'(sa.gnt), 32'd1);
      sa.req = '0;
      step();
      chk("cancel2_busy", 32'(sa.busy), 32'd0);

      // Abort on the 2nd in-window ce of a ch1 window; ch0 follows.
      sa.req = 4'b0011;
      step();
      chk("abort_grant_ch", 32'(sa.ch), 32'd1);
      for (int i = 0; i < 8 && !sa.Tm; i++) step();
      chk("abort_tm_rise", 32'(sa.Tm), 32'd1);
      for (int i = 0; i < 4 && !sa.ce; i++) step();
      step();
      for (int i = 0; i < 4 && !sa.ce; i++) step();
      sa.abort = 1'b1;
      step();
      sa.abort = 1'b0;
      chk("abort_tm", 32'(sa.Tm), 32'd0);
      chk("abort_gnt", 32'(sa.gnt), 32'd0);
      chk("abort_done", 32'(sa.done), 32'd0);
      chk("abort_busy", 32'(sa.busy), 32'd0);
      step();
      chk("abort_next_gnt", 32'(sa.gnt), 32'd1);
      chk("abort_next_ch", 32'(sa.ch), 32'd0);
      sa.req = '0;
      step();

      // Asynchronous reset in the middle of a window.
      sa.req = 4'b1000;
      step();
      chk("ar_grant_ch", 32'(sa.ch), 32'd3);
      for (int i = 0; i < 8 && !sa.Tm; i++) step();
      step();
      step();
      chk("ar_tm_before", 32'(sa.Tm), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_tm", 32'(sa.Tm), 32'd0);
      chk("ar_gnt", 32'(sa.gnt), 32'd0);
      chk("ar_busy", 32'(sa.busy), 32'd0);
      chk("ar_done", 32'(sa.done), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("ar_regrant_gnt", 32'(sa.gnt), 32'h8);
      chk("ar_regrant_ch", 32'(sa.ch), 32'd3);
      measure_window(3);
      sa.req = '0;

      // GAP=0 with ce tied high.
      sb.req = 4'b0011;
      step();
      chk("g0_gnt0", 32'(sb.gnt), 32'd1);
      chk("g0_arm_tm", 32'(sb.Tm), 32'd0);
      step();
      chk("g0_tm_rise", 32'(sb.Tm), 32'd1);
      repeat (3) begin
         step();
         chk("g0_tm_high", 32'(sb.Tm), 32'd1);
      end
      step();
      chk("g0_tm_fall", 32'(sb.Tm), 32'd0);
      chk("g0_done", 32'(sb.done), 32'd1);
      chk("g0_done_ch", 32'(sb.ch), 32'd0);
      chk("g0_gnt_clr", 32'(sb.gnt), 32'd0);
      step();
      chk("g0_gnt1", 32'(sb.gnt), 32'd2);
      chk("g0_ch1", 32'(sb.ch), 32'd1);
      chk("g0_done_low", 32'(sb.done), 32'd0);
      chk("g0_tm_low2", 32'(sb.Tm), 32'd0);
      step();
      chk("g0_tm_rise2", 32'(sb.Tm), 32'd1);
      sb.req = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
